mem_arbiter: RTL

- Shares a single SoC memory port between the IFU fetch path and the LSU load/store path.
- Sits between the core's fetch/LSU request interfaces and the memory bus.
- Accepts level-held requests with valid/ready on the memory side.
- Routes each response back to the requester that issued it, and produces a timeout error response when memory never answers.

---
 rtl/soc_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_rr_arb2.sv | 23 ++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/soc_arb_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter.
// Holds the FSM state and grant-owner encodings plus a counter-width helper.
package soc_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IFU  = 2'd1,
        GNT_LSU  = 2'd2
    } arb_gnt_t;

    // Bit positions in the one-hot request/grant vectors.
    localparam int REQ_IFU = 0;
    localparam int REQ_LSU = 1;

    // Width of the timeout counter; a disabled timeout still
    // needs a one-bit register so the datapath stays legal.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker (purely combinational).
// Ports: req[1:0] (bit0 IFU, bit1 LSU), last_grant, grant[1:0] one-hot.
module rr_arb2
    import soc_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On a tie the requester that was not served last wins;
            // anything other than an IFU history favours the IFU.
            2'b11:   grant = (last_grant == GNT_IFU) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one SoC memory port between the IFU fetch path and the LSU path.
// Ports: ifu_* / lsu_* level-held requests with 1-cycle response strobes,
// mem_* valid/ready request channel plus response strobe, busy status.
module mem_arbiter
    import soc_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                ifu_reqValid,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_respValid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_respErr,

    input  logic                lsu_reqValid,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_respValid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_respErr,

    output logic                mem_reqValid,
    input  logic                mem_reqReady,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_respValid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = cnt_width(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    arb_state_t          state;
    arb_gnt_t            owner;
    arb_gnt_t            last_grant;
    logic [CNT_W-1:0]    cnt;

    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;

    logic [1:0]          req;
    logic [1:0]          grant;
    logic                resp_hit;
    logic                tmo_hit;
    logic                ifu_own;
    logic                lsu_own;

    assign req[REQ_IFU] = ifu_reqValid;
    assign req[REQ_LSU] = lsu_reqValid;

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Memory responses only count while waiting; anything else is stray.
    assign resp_hit = (state == ARB_WAIT) && mem_respValid;

    // cnt holds the number of cycles since the grant, counting the
    // first ARB_REQ cycle as 1, so the limit fires on cycle TIMEOUT_CYCLES.
    // A real response in the same cycle wins over the timeout.
    assign tmo_hit = (TIMEOUT_CYCLES != 0)
                  && (state != ARB_IDLE)
                  && (cnt == CNT_LIMIT)
                  && !resp_hit;

    assign ifu_own = (owner == GNT_IFU);
    assign lsu_own = (owner == GNT_LSU);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= GNT_NONE;
            last_grant <= GNT_LSU;
            cnt        <= '0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant[REQ_IFU]) begin
                        state      <= ARB_REQ;
                        owner      <= GNT_IFU;
                        last_grant <= GNT_IFU;
                        cnt        <= CNT_ONE;
                        addr_q     <= ifu_addr;
                        wen_q      <= 1'b0;
                        wdata_q    <= '0;
                        wmask_q    <= '0;
                    end else if (grant[REQ_LSU]) begin
                        state      <= ARB_REQ;
                        owner      <= GNT_LSU;
                        last_grant <= GNT_LSU;
                        cnt        <= CNT_ONE;
                        addr_q     <= lsu_addr;
                        wen_q      <= lsu_wen;
                        wdata_q    <= lsu_wdata;
                        wmask_q    <= lsu_wmask;
                    end
                end
                ARB_REQ: begin
                    if (tmo_hit) begin
                        state <= ARB_IDLE;
                        owner <= GNT_NONE;
                        cnt   <= '0;
                    end else begin
                        if (mem_reqReady) begin
                            state <= ARB_WAIT;
                        end
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                ARB_WAIT: begin
                    if (resp_hit || tmo_hit) begin
                        state <= ARB_IDLE;
                        owner <= GNT_NONE;
                        cnt   <= '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    owner <= GNT_NONE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // The request is withdrawn in the cycle the timeout fires.
    assign mem_reqValid = (state == ARB_REQ) && !tmo_hit;
    assign mem_addr     = addr_q;
    assign mem_wen      = wen_q;
    assign mem_wdata    = wdata_q;
    assign mem_wmask    = wmask_q;
    assign busy         = (state != ARB_IDLE);

    assign ifu_respValid = ifu_own && (resp_hit || tmo_hit);
    assign ifu_respErr   = ifu_own && tmo_hit;
    assign ifu_rdata     = (ifu_own && resp_hit) ? mem_rdata : '0;

    assign lsu_respValid = lsu_own && (resp_hit || tmo_hit);
    assign lsu_respErr   = lsu_own && tmo_hit;
    assign lsu_rdata     = (lsu_own && resp_hit) ? mem_rdata : '0;

endmodule
